// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: memory-mapped 8N1 UART transmitter with an 8-entry byte FIFO,
// programmable bit divisor and a level interrupt when the transmitter drains.
// Optional build macro UART_TX_PARITY_EN adds a parity bit (CTRL[1]=1 selects odd).
`timescale 1ns/1ps
module uart_tx_mmio #(
  parameter int          FIFO_AW   = 3,
  parameter logic [15:0] DIV_RESET = 16'd434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [3:0]  sel,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  output logic        txd,
  output logic        irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t             state, state_nxt;
  logic [7:0]         fifo_mem [DEPTH];
  logic [FIFO_AW:0]   wr_ptr, rd_ptr;
  logic [7:0]         shift_q;
  logic [2:0]         bit_idx;
  logic [15:0]        cnt;
  logic [15:0]        divisor;
  logic               ie;
  logic               ctrl_odd;
  logic               ovf;
  logic               irq_q;

  logic               wr_en, push, ovf_set, ovf_clr;
  logic               full, empty, busy, tick;
  logic               pop, shift_en;
  logic               unused_bits;

  assign wr_en   = ce & we & (sel != 4'b0000);
  assign push    = wr_en & (addr[3:2] == 2'b00);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
  assign ovf_set = push & full;
  assign ovf_clr = wr_en & (addr[3:2] == 2'b01) & data_i[4];
  assign busy    = (state != S_IDLE);
  assign tick    = (cnt == 16'd0);
  assign irq_o   = irq_q;

  assign unused_bits = ^{addr[31:4], addr[1:0], data_i[31:16]};

  // FIFO storage: the array holds data only, so it is not reset
  always_ff @(posedge clk) begin
    if (push && !full)
      fifo_mem[wr_ptr[FIFO_AW-1:0]] <= data_i[7:0];
  end

  // FIFO pointers; full is judged before any same-cycle pop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Control registers: sticky overflow (set beats clear), CTRL, DIVISOR (0 stored as 1)
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf     <= 1'b0;
      ie      <= 1'b0;
      divisor <= DIV_RESET;
    end else begin
      if (ovf_set)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (wr_en && addr[3:2] == 2'b10)
        ie <= data_i[0];
      if (wr_en && addr[3:2] == 2'b11)
        divisor <= (data_i[15:0] == 16'd0) ? 16'd1 : data_i[15:0];
    end
  end

`ifdef UART_TX_PARITY_EN
  logic par_q;

  // Parity select bit in CTRL[1]
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ctrl_odd <= 1'b0;
    else if (wr_en && addr[3:2] == 2'b10)
      ctrl_odd <= data_i[1];
  end

  // Parity of the byte being sent, captured when it leaves the FIFO
  always_ff @(posedge clk) begin
    if (pop)
      par_q <= ^fifo_mem[rd_ptr[FIFO_AW-1:0]];
  end
`else
  assign ctrl_odd = 1'b0;
`endif

  // TX state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  // TX next-state, pop/shift strobes and serial output level
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    shift_en  = 1'b0;
    txd       = 1'b1;
    case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        txd = 1'b0;
        if (tick)
          state_nxt = S_DATA;
      end
      S_DATA: begin
        txd = shift_q[0];
        if (tick) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        txd = par_q ^ ctrl_odd;
        if (tick)
          state_nxt = S_STOP;
      end
`endif
      S_STOP: begin
        if (tick) begin
          if (!empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Bit timer and data-bit index; the divisor is sampled at every bit boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      if (pop)
        cnt <= divisor - 16'd1;
      else if (state != S_IDLE)
        cnt <= tick ? (divisor - 16'd1) : (cnt - 16'd1);
      if (pop)
        bit_idx <= 3'd0;
      else if (shift_en)
        bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register: loaded from the FIFO head, shifted LSB first
  always_ff @(posedge clk) begin
    if (pop)
      shift_q <= fifo_mem[rd_ptr[FIFO_AW-1:0]];
    else if (shift_en)
      shift_q <= {1'b0, shift_q[7:1]};
  end

  // Registered interrupt: enabled, FIFO drained and transmitter idle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      irq_q <= 1'b0;
    else
      irq_q <= ie & empty & ~busy;
  end

  // Read mux; reads have no side effects
  always_comb begin
    data_o = 32'd0;
    if (ce && !we) begin
      case (addr[3:2])
        2'b01:   data_o = {27'd0, ovf, busy, empty, full, 1'b0};
        2'b10:   data_o = {30'd0, ctrl_odd, ie};
        2'b11:   data_o = {16'd0, divisor};
        default: data_o = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: bus-level stimulus with randomized bytes and divisors; the
// serial line is recorded per cycle and compared with frames built from the bytes.
`timescale 1ns/1ps
module tb_uart_tx_mmio;

`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int TRACE_N = 32768;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [3:0]  sel = 4'd0;
  logic [31:0] data_i = 32'd0;
  logic [31:0] data_o;
  logic        txd;
  logic        irq_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  logic trace  [TRACE_N];
  logic itrace [TRACE_N];

  uart_tx_mmio dut (
    .clk(clk), .rst(rst), .ce(ce), .we(we), .addr(addr), .sel(sel),
    .data_i(data_i), .data_o(data_o), .txd(txd), .irq_o(irq_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < TRACE_N) begin
      trace[cyc]  = txd;
      itrace[cyc] = irq_o;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic write_reg_sel(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s,
                               output int c);
    @(negedge clk);
    ce = 1'b1; we = 1'b1; sel = s; addr = {28'd0, r, 2'b00}; data_i = d;
    @(posedge clk);
    #1;
    ce = 1'b0; we = 1'b0; sel = 4'd0;
    c = cyc;
  endtask

  task automatic write_reg(input logic [1:0] r, input logic [31:0] d, output int c);
    write_reg_sel(r, d, 4'($urandom_range(1, 15)), c);
  endtask

  task automatic read_reg(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; sel = 4'($urandom_range(0, 15));
    addr = {28'd0, r, 2'b00} | 32'($urandom_range(0, 3)) | 32'h100;
    #1;
    d = data_o;
    ce = 1'b0;
  endtask

  // Expected frame per byte: start 0, 8 data bits LSB first, optional parity, stop 1,
  // frames contiguous, each level exactly div cycles.
  task automatic check_stream(input string tag, input int start, input int div,
                              input logic [7:0] bytes[$], input logic odd);
    int endc;
    endc = start + bytes.size() * NBITS * div;
    while (cyc <= endc + 2) @(posedge clk);
    @(negedge clk);
    check_val({tag, " pre-idle"}, 32'(trace[start - 1]), 32'd1);
    for (int f = 0; f < bytes.size(); f++) begin
      logic [10:0] lv, obs;
      int glitches, base;
      lv = '0; obs = '0; glitches = 0;
      base = start + f * NBITS * div;
      lv[0] = 1'b0;
      for (int b = 0; b < 8; b++) lv[b + 1] = bytes[f][b];
      if (NBITS == 11) lv[9] = (^bytes[f]) ^ odd;
      lv[NBITS - 1] = 1'b1;
      for (int i = 0; i < NBITS; i++) begin
        obs[i] = trace[base + i * div + div / 2];
        for (int j = 0; j < div; j++)
          if (trace[base + i * div + j] !== lv[i]) glitches++;
      end
      check_val($sformatf("%s frame%0d", tag, f), 32'(obs), 32'(lv));
      check_val($sformatf("%s timing%0d", tag, f), 32'(glitches), 32'd0);
    end
    check_val({tag, " post-idle"}, 32'(trace[endc]), 32'd1);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  q[$];
    int c, c0, c2, ones, e, div, n;

    // reset held low
    repeat (3) @(negedge clk);
    check_val("rst txd", 32'(txd), 32'd1);
    check_val("rst irq", 32'(irq_o), 32'd0);
    @(negedge clk);
    ce = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    check_val("rst status", data_o, 32'h4);
    ce = 1'b0;
    #1;
    check_val("ce0 data_o", data_o, 32'h0);
    @(negedge clk);
    rst = 1'b1;

    read_reg(2'b01, rd); check_val("status", rd, 32'h4);
    read_reg(2'b11, rd); check_val("divisor", rd, 32'd434);
    read_reg(2'b10, rd); check_val("ctrl", rd, 32'h0);
    read_reg(2'b00, rd); check_val("txdata read", rd, 32'h0);

    // CTRL reserved bits and sel=0 writes
    write_reg(2'b10, 32'hFFFF_FFFE, c);
    read_reg(2'b10, rd);
`ifdef UART_TX_PARITY_EN
    check_val("ctrl mask", rd, 32'h2);
`else
    check_val("ctrl mask", rd, 32'h0);
`endif
    write_reg(2'b10, 32'h0, c);
    write_reg_sel(2'b11, 32'd5, 4'd0, c);
    read_reg(2'b11, rd); check_val("sel0 write", rd, 32'd434);

    // single byte 0xA5 at 4 cycles per bit
    write_reg(2'b11, 32'd4, c);
    read_reg(2'b11, rd); check_val("divisor 4", rd, 32'd4);
    write_reg(2'b00, 32'hFFFF_FFA5, c0);
    while (cyc < c0 + 13) @(posedge clk);
    read_reg(2'b01, rd); check_val("status busy", rd, 32'hC);
    q = '{8'hA5};
    check_stream("a5", c0 + 1, 4, q, 1'b0);
    begin
      logic [8:0] w;
      for (int i = 0; i < 9; i++) w[i] = trace[c0 + 1 + i * 4 + 2];
      check_val("a5 wave", 32'(w), 32'h14A);
    end
    read_reg(2'b01, rd); check_val("status idle", rd, 32'h4);

    // overflow: one byte in flight then nine more writes, last one dropped
    write_reg(2'b11, 32'd2, c);
    q = {};
    for (int i = 0; i < 10; i++) q.push_back(8'($urandom));
    write_reg(2'b00, {24'($urandom), q[0]}, c0);
    for (int i = 1; i < 10; i++) write_reg(2'b00, {24'd0, q[i]}, c);
    read_reg(2'b01, rd); check_val("status ovf full", rd, 32'h1A);
    q.pop_back();
    check_stream("ovf", c0 + 1, 2, q, 1'b0);
    read_reg(2'b01, rd); check_val("ovf sticky", rd, 32'h14);
    write_reg(2'b01, 32'hEF, c);
    read_reg(2'b01, rd); check_val("ovf keep", rd, 32'h14);
    write_reg(2'b01, 32'h10, c);
    read_reg(2'b01, rd); check_val("ovf clear", rd, 32'h4);

    // interrupt
    write_reg(2'b11, 32'd3, c);
    write_reg(2'b10, 32'h1, c);
    @(negedge clk); @(negedge clk);
    check_val("irq idle", 32'(irq_o), 32'd1);
    write_reg(2'b00, 32'h55, c0);
    q = '{8'h55};
    check_stream("irq55", c0 + 1, 3, q, 1'b0);
    e = c0 + 1 + NBITS * 3;
    ones = 0;
    for (int i = c0 + 1; i <= e; i++) if (itrace[i] !== 1'b0) ones++;
    check_val("irq write cycle", 32'(itrace[c0]), 32'd1);
    check_val("irq low in frame", 32'(ones), 32'd0);
    check_val("irq after stop", 32'(itrace[e + 1]), 32'd1);
    write_reg(2'b00, 32'h3C, c2);
    @(negedge clk); @(negedge clk);
    check_val("irq hold", 32'(itrace[c2]), 32'd1);
    check_val("irq drop", 32'(itrace[c2 + 1]), 32'd0);
    q = '{8'h3C};
    check_stream("irq3c", c2 + 1, 3, q, 1'b0);
    write_reg(2'b10, 32'h0, c);
    @(negedge clk); @(negedge clk);
    check_val("irq disabled", 32'(irq_o), 32'd0);

    // divisor 0 is stored as 1; back-to-back frames
    write_reg(2'b11, 32'd0, c);
    read_reg(2'b11, rd); check_val("divisor zero", rd, 32'd1);
    q = '{8'($urandom), 8'($urandom)};
    write_reg(2'b00, {24'd0, q[0]}, c0);
    write_reg(2'b00, {24'd0, q[1]}, c);
    check_stream("div1", c0 + 1, 1, q, 1'b0);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      div = $urandom_range(1, 6);
      n = $urandom_range(1, 8);
      write_reg(2'b11, 32'(div), c);
      q = {};
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      write_reg(2'b00, {24'($urandom), q[0]}, c0);
      for (int i = 1; i < n; i++) write_reg(2'b00, {24'($urandom), q[i]}, c);
      check_stream($sformatf("rnd%0d", r), c0 + 1, div, q, 1'b0);
      read_reg(2'b01, rd); check_val($sformatf("rnd%0d status", r), rd, 32'h4);
    end

`ifdef UART_TX_PARITY_EN
    write_reg(2'b11, 32'd2, c);
    write_reg(2'b00, 32'h07, c0);
    q = '{8'h07};
    check_stream("par even", c0 + 1, 2, q, 1'b0);
    check_val("par bit", 32'(trace[c0 + 1 + 9 * 2 + 1]), 32'd1);
    write_reg(2'b10, 32'h2, c);
    write_reg(2'b00, 32'h07, c0);
    check_stream("par odd", c0 + 1, 2, q, 1'b1);
    write_reg(2'b10, 32'h0, c);
`endif

    // reset in the middle of a data bit
    write_reg(2'b11, 32'd4, c);
    write_reg(2'b00, 32'h00, c0);
    write_reg(2'b00, 32'hFF, c);
    write_reg(2'b00, 32'h81, c);
    while (cyc < c0 + 1 + 4 * 3 + 1) @(posedge clk);
    @(negedge clk);
    check_val("pre-reset txd", 32'(txd), 32'd0);
    #2;
    rst = 1'b0;
    ce = 1'b1; we = 1'b0; addr = 32'h4;
    #1;
    check_val("async txd", 32'(txd), 32'd1);
    check_val("async status", data_o, 32'h4);
    ce = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    c = cyc;
    repeat (20) @(negedge clk);
    ones = 0;
    for (int i = c; i < c + 18; i++) if (trace[i] !== 1'b1) ones++;
    check_val("post-reset idle", 32'(ones), 32'd0);
    read_reg(2'b01, rd); check_val("post-reset status", rd, 32'h4);
    read_reg(2'b11, rd); check_val("post-reset divisor", rd, 32'd434);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
